lif_neuron: RTL and testbench
=============================

# lif_neuron

- Clocked, parametrised leaky integrate-and-fire neuron. Successor to the combinational accumulate-and-threshold neuron.
- Keeps a registered membrane potential across cycles, with optional leak, saturation, a refractory period and a first-spike (winner) mode.
- Records the time index of each output spike within a gamma window.
- Sits between the input spike crossbar and the per-column WTA / STDP logic; one instance per neuron of a layer.

## Interface
- NUM_INPUTS, 16, number of synaptic inputs
- WBITS, 3, unsigned weight width
- POT_BITS, 8, membrane potential width; the potential saturates at 2^POT_BITS-1
- THRESHOLD, 20, firing threshold; legal range 1..2^POT_BITS-1
- LEAK_SHIFT, 0, leak is potential>>LEAK_SHIFT per integrating cycle; 0 disables leak
- REFRAC_CYCLES, 2, cycles during which inputs are ignored after a spike; 0 allowed
- MODE, 0, 0 = multi-spike LIF; 1 = first-spike only per gamma window
- TBITS, 4, width of the gamma-window time counter
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- gamma_start  input  1  opens a new gamma window: clears potential and time counter
- valid_in  input  1  spikes_in is meaningful this cycle
- spikes_in  input  NUM_INPUTS  one bit per synapse
- weights  input  NUM_INPUTS x WBITS  per-synapse unsigned weights
- spike_out  output  1  one-cycle registered spike pulse
- spike_time  output  TBITS  time index of the most recent spike
- fired  output  1  at least one spike in the current window (sticky)
- potential  output  POT_BITS  current membrane potential (observation)

## Operation
- States:
  - IDLE: after reset; inputs ignored.
  - INTEGRATE.
  - REFRACT.
  - DONE: MODE=1 only.
- Priority: reset > gamma_start > state behaviour.
- gamma_start, from any state:
  - Time counter is set to 0 for that cycle; the next state is INTEGRATE.
  - fired is cleared.
  - Inputs in the same cycle are integrated from a zero potential: next = sat(0 + sum).
- Sum:
  - sum = Σ weights[i] over i where spikes_in[i]=1, taken only if valid_in=1; otherwise sum = 0.
  - sum width is WBITS + clog2(NUM_INPUTS), so it never overflows.
- INTEGRATE update:
  - leak = LEAK_SHIFT ? pot>>LEAK_SHIFT : 0.
  - next = pot - leak + sum, computed wide, then saturated to 2^POT_BITS-1.
- Fire, when next >= THRESHOLD:
  - Potential is loaded with 0.
  - spike_out=1 next cycle.
  - spike_time is loaded with this cycle's time index.
  - fired is set.
  - Next state: MODE=1 → DONE. Else REFRAC_CYCLES>0 → REFRACT, otherwise stay in INTEGRATE.
- REFRACT:
  - Lasts exactly REFRAC_CYCLES cycles, counted by a down-counter.
  - Inputs are ignored and the potential holds 0.
  - Returns to INTEGRATE, and integrates in the cycle after the last refractory cycle.
- DONE: inputs ignored and potential held at 0 until gamma_start.
- Time counter:
  - Increments every cycle after gamma_start and saturates at 2^TBITS-1.
  - Integration continues while it is saturated; spike_time then reports the saturated value.
- spike_time and fired hold their values until the next spike, gamma_start or reset.

## Timing
- Reset values: spike_out=0, spike_time=0, fired=0, potential=0, state IDLE, counters 0.
- Reset asserted mid-window or mid-refractory aborts immediately. Nothing resumes until gamma_start.
- Latency: inputs at cycle N → spike_out high during cycle N+1 (one register stage).
- spike_out is never high on two consecutive cycles unless REFRAC_CYCLES=0 and MODE=0.
- gamma_start arriving in the same cycle as a would-be refractory exit: gamma_start wins.
- gamma_start during a cycle in which spike_out is high: the pulse completes; the new window starts cleanly.
- Minimum spike spacing in MODE 0 is REFRAC_CYCLES+1 cycles.

## Test plan
- No gamma window: after reset, drive all 16 inputs with weight 7 and valid_in=1 → potential stays 0 and spike_out stays 0.
- Basic fire (defaults):
  - Cycle 0: gamma_start with inputs 0,1 at weight 7 → potential 14.
  - Cycle 1: input 2 at weight 7 → 21 ≥ 20, so spike_out=1 in cycle 2, spike_time=1, fired=1, potential=0.
- Refractory: gamma_start at cycle 0, then all inputs at weight 7 every cycle (sum 112) → spike_out in cycles 1, 4, 7; spike_time 0, 3, 6.
- Saturation: THRESHOLD=255, sum 112 per cycle → potential 112, 224, 255; fire at cycle 2; spike_out in cycle 3.
- Leak: LEAK_SHIFT=1, sum 8 per cycle, THRESHOLD=20 → potential 8, 12, 14, 15, 16, 16 …; never fires.
- MODE=1 and aborts:
  - After the first spike the neuron enters DONE; further inputs are ignored and fired stays 1.
  - gamma_start mid-refractory restarts with potential = that cycle's sum and time 0.
  - reset mid-integration clears all outputs asynchronously.

Source files
------------

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron
// Purpose  : Clocked leaky integrate-and-fire neuron. Keeps a membrane
//            potential across cycles, adds the weighted sum of active
//            synapses, applies an optional shift-based leak, saturates, and
//            fires a one-cycle registered pulse when the threshold is reached.
//            Supports a refractory period and a first-spike-only mode. The
//            time index of each spike within the current gamma window is
//            recorded.
// Ports    : clk          - clock, rising edge
//            reset        - asynchronous active-high reset
//            gamma_start  - opens a new gamma window (clears potential/time)
//            valid_in     - spikes_in qualifier
//            spikes_in    - one bit per synapse
//            weights      - NUM_INPUTS packed unsigned weights, synapse i at
//                           [i*WBITS +: WBITS]
//            spike_out    - one-cycle spike pulse
//            spike_time   - time index of the most recent spike
//            fired        - sticky: at least one spike in this window
//            potential    - current membrane potential
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron #(
  parameter int NUM_INPUTS    = 16,
  parameter int WBITS         = 3,
  parameter int POT_BITS      = 8,
  parameter int THRESHOLD     = 20,
  parameter int LEAK_SHIFT    = 0,
  parameter int REFRAC_CYCLES = 2,
  parameter int MODE          = 0,
  parameter int TBITS         = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gamma_start,
  input  logic                        valid_in,
  input  logic [NUM_INPUTS-1:0]       spikes_in,
  input  logic [NUM_INPUTS*WBITS-1:0] weights,
  output logic                        spike_out,
  output logic [TBITS-1:0]            spike_time,
  output logic                        fired,
  output logic [POT_BITS-1:0]         potential
);

  localparam int SUM_W = WBITS + $clog2(NUM_INPUTS);
  // One extra bit over the wider operand so pot + sum cannot wrap.
  localparam int NW    = ((POT_BITS > SUM_W) ? POT_BITS : SUM_W) + 1;
  localparam int RC_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

  localparam logic [POT_BITS-1:0] POT_MAX = {POT_BITS{1'b1}};
  localparam logic [POT_BITS-1:0] THR     = POT_BITS'(THRESHOLD);
  localparam logic [TBITS-1:0]    T_MAX   = {TBITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INTEGRATE = 2'd1,
    S_REFRACT   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              state_q;
  logic [POT_BITS-1:0] pot_q;
  logic [TBITS-1:0]    t_q;
  logic [RC_W-1:0]     rc_q;
  logic                spike_q;
  logic [TBITS-1:0]    stime_q;
  logic                fired_q;

  logic [SUM_W-1:0]    sum_w;
  logic                integ_w;
  logic [POT_BITS-1:0] base_w;
  logic [POT_BITS-1:0] leak_w;
  logic [NW-1:0]       wide_w;
  logic [POT_BITS-1:0] sat_w;
  logic                fire_w;
  logic [TBITS-1:0]    tnow_w;
  state_t              post_w;

  always_comb begin
    sum_w = '0;
    if (valid_in) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (spikes_in[i]) begin
          sum_w = sum_w + SUM_W'(weights[i*WBITS +: WBITS]);
        end
      end
    end

    // gamma_start integrates from a zero potential regardless of state.
    integ_w = gamma_start || (state_q == S_INTEGRATE);
    base_w  = gamma_start ? '0 : pot_q;
    leak_w  = (LEAK_SHIFT != 0 && !gamma_start) ? (pot_q >> LEAK_SHIFT) : '0;
    // leak_w <= base_w always, so the subtraction cannot underflow.
    wide_w  = NW'(base_w) - NW'(leak_w) + NW'(sum_w);
    sat_w   = (wide_w > NW'(POT_MAX)) ? POT_MAX : wide_w[POT_BITS-1:0];
    fire_w  = integ_w && (sat_w >= THR);

    // Time index of the current cycle: a gamma_start cycle is index 0.
    tnow_w  = gamma_start ? '0 : t_q;

    if (MODE == 1) begin
      post_w = S_DONE;
    end else if (REFRAC_CYCLES > 0) begin
      post_w = S_REFRACT;
    end else begin
      post_w = S_INTEGRATE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pot_q   <= '0;
      t_q     <= '0;
      rc_q    <= '0;
      spike_q <= 1'b0;
      stime_q <= '0;
      fired_q <= 1'b0;
    end else begin
      spike_q <= fire_w;

      // The window clock only runs once a window has been opened.
      if (gamma_start || state_q != S_IDLE) begin
        t_q <= (tnow_w == T_MAX) ? T_MAX : tnow_w + TBITS'(1);
      end

      if (fire_w) begin
        pot_q   <= '0;
        stime_q <= tnow_w;
        fired_q <= 1'b1;
        state_q <= post_w;
        rc_q    <= RC_W'(REFRAC_CYCLES);
      end else if (gamma_start) begin
        pot_q   <= sat_w;
        stime_q <= '0;
        fired_q <= 1'b0;
        state_q <= S_INTEGRATE;
        rc_q    <= '0;
      end else begin
        case (state_q)
          S_INTEGRATE: begin
            pot_q <= sat_w;
          end
          S_REFRACT: begin
            pot_q <= '0;
            // Last refractory cycle: integrate again on the next one.
            if (rc_q <= RC_W'(1)) begin
              state_q <= S_INTEGRATE;
              rc_q    <= '0;
            end else begin
              rc_q <= rc_q - RC_W'(1);
            end
          end
          default: begin
            pot_q <= '0;
          end
        endcase
      end
    end
  end

  assign spike_out  = spike_q;
  assign spike_time = stime_q;
  assign fired      = fired_q;
  assign potential  = pot_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron
// Purpose  : Directed self-checking bench for lif_neuron. Four instances
//            share the stimulus: defaults, THRESHOLD=255, LEAK_SHIFT=1, MODE=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        reset;
  logic        gamma_start;
  logic        valid_in;
  logic [15:0] spikes_in;
  logic [47:0] weights;

  logic       so_def, so_sat, so_lk, so_m1;
  logic [3:0] st_def, st_sat, st_lk, st_m1;
  logic       fd_def, fd_sat, fd_lk, fd_m1;
  logic [7:0] pt_def, pt_sat, pt_lk, pt_m1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_neuron u_def (
    .clk(clk), .reset(reset), .gamma_start(gamma_start), .valid_in(valid_in),
    .spikes_in(spikes_in), .weights(weights),
    .spike_out(so_def), .spike_time(st_def), .fired(fd_def), .potential(pt_def));

  lif_neuron #(.THRESHOLD(255)) u_sat (
    .clk(clk), .reset(reset), .gamma_start(gamma_start), .valid_in(valid_in),
    .spikes_in(spikes_in), .weights(weights),
    .spike_out(so_sat), .spike_time(st_sat), .fired(fd_sat), .potential(pt_sat));

  lif_neuron #(.LEAK_SHIFT(1)) u_lk (
    .clk(clk), .reset(reset), .gamma_start(gamma_start), .valid_in(valid_in),
    .spikes_in(spikes_in), .weights(weights),
    .spike_out(so_lk), .spike_time(st_lk), .fired(fd_lk), .potential(pt_lk));

  lif_neuron #(.MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .gamma_start(gamma_start), .valid_in(valid_in),
    .spikes_in(spikes_in), .weights(weights),
    .spike_out(so_m1), .spike_time(st_m1), .fired(fd_m1), .potential(pt_m1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic gs, input logic v, input logic [15:0] sp);
    gamma_start = gs;
    valid_in    = v;
    spikes_in   = sp;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    weights = {16{3'd7}};
    step();
    step();
    checks++;
    if ({so_def, st_def, fd_def, pt_def} !== 14'd0) begin
      failures++;
      $display("FAIL reset_def got so=%0b st=%0d fd=%0b pt=%0d want all 0", so_def, st_def, fd_def, pt_def);
    end
    checks++;
    if ({so_m1, st_m1, fd_m1, pt_m1} !== 14'd0) begin
      failures++;
      $display("FAIL reset_m1 got so=%0b st=%0d fd=%0b pt=%0d want all 0", so_m1, st_m1, fd_m1, pt_m1);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_window();
    drive(1'b0, 1'b1, 16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (pt_def !== 8'd0 || so_def !== 1'b0) begin
        failures++;
        $display("FAIL no_window c=%0d got pt=%0d so=%0b want pt=0 so=0", c, pt_def, so_def);
      end
    end
  endtask

  task automatic test_basic_fire();
    drive(1'b1, 1'b1, 16'h0003);
    step();
    checks++;
    if (pt_def !== 8'd14 || so_def !== 1'b0) begin
      failures++;
      $display("FAIL basic_c0 got pt=%0d so=%0b want pt=14 so=0", pt_def, so_def);
    end
    drive(1'b0, 1'b1, 16'h0004);
    step();
    checks++;
    if (so_def !== 1'b1 || st_def !== 4'd1 || fd_def !== 1'b1 || pt_def !== 8'd0) begin
      failures++;
      $display("FAIL basic_fire got so=%0b st=%0d fd=%0b pt=%0d want so=1 st=1 fd=1 pt=0",
               so_def, st_def, fd_def, pt_def);
    end
    drive(1'b0, 1'b0, 16'h0000);
    step();
    checks++;
    if (so_def !== 1'b0 || fd_def !== 1'b1 || st_def !== 4'd1) begin
      failures++;
      $display("FAIL basic_after got so=%0b fd=%0b st=%0d want so=0 fd=1 st=1", so_def, fd_def, st_def);
    end
  endtask

  // All synapses at weight 7 every cycle (sum 112). Also exercises saturation
  // on u_sat and first-spike behaviour on u_m1.
  task automatic test_refractory();
    logic       exp_so;
    logic [3:0] exp_st;
    exp_st = 4'd0;
    weights = {16{3'd7}};
    for (int c = 0; c < 9; c++) begin
      drive(c == 0, 1'b1, 16'hFFFF);
      step();
      // Now observing cycle c+1.
      exp_so = (c + 1 == 1) || (c + 1 == 4) || (c + 1 == 7);
      if (exp_so) exp_st = 4'(c);
      checks++;
      if (so_def !== exp_so || st_def !== exp_st || fd_def !== 1'b1) begin
        failures++;
        $display("FAIL refrac cyc=%0d got so=%0b st=%0d fd=%0b want so=%0b st=%0d fd=1",
                 c + 1, so_def, st_def, fd_def, exp_so, exp_st);
      end
      if (c < 3) begin
        checks++;
        if (c == 0 && (pt_sat !== 8'd112 || so_sat !== 1'b0)) begin
          failures++;
          $display("FAIL sat_c0 got pt=%0d so=%0b want pt=112 so=0", pt_sat, so_sat);
        end else if (c == 1 && (pt_sat !== 8'd224 || so_sat !== 1'b0)) begin
          failures++;
          $display("FAIL sat_c1 got pt=%0d so=%0b want pt=224 so=0", pt_sat, so_sat);
        end else if (c == 2 && (pt_sat !== 8'd0 || so_sat !== 1'b1 || st_sat !== 4'd2)) begin
          failures++;
          $display("FAIL sat_fire got pt=%0d so=%0b st=%0d want pt=0 so=1 st=2", pt_sat, so_sat, st_sat);
        end
      end
      checks++;
      if (so_m1 !== (c == 0) || st_m1 !== 4'd0 || fd_m1 !== 1'b1 || pt_m1 !== 8'd0) begin
        failures++;
        $display("FAIL mode1 cyc=%0d got so=%0b st=%0d fd=%0b pt=%0d want so=%0b st=0 fd=1 pt=0",
                 c + 1, so_m1, st_m1, fd_m1, pt_m1, (c == 0));
      end
    end
  endtask

  task automatic test_leak();
    logic [7:0] exp_pt [7];
    exp_pt = '{8'd8, 8'd12, 8'd14, 8'd15, 8'd16, 8'd16, 8'd16};
    weights = {16{3'd1}};
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 1'b1, 16'h00FF);
      step();
      checks++;
      if (pt_lk !== exp_pt[c] || so_lk !== 1'b0 || fd_lk !== 1'b0) begin
        failures++;
        $display("FAIL leak c=%0d got pt=%0d so=%0b fd=%0b want pt=%0d so=0 fd=0",
                 c, pt_lk, so_lk, fd_lk, exp_pt[c]);
      end
    end
  endtask

  task automatic test_gamma_mid_refract();
    weights = {16{3'd7}};
    drive(1'b1, 1'b1, 16'hFFFF);
    step();
    checks++;
    if (so_def !== 1'b1 || st_def !== 4'd0) begin
      failures++;
      $display("FAIL gmr_fire got so=%0b st=%0d want so=1 st=0", so_def, st_def);
    end
    // Cycle 1 is refractory; a new window opens here with sum 7.
    drive(1'b1, 1'b1, 16'h0001);
    step();
    checks++;
    if (pt_def !== 8'd7 || so_def !== 1'b0 || fd_def !== 1'b0) begin
      failures++;
      $display("FAIL gmr_restart got pt=%0d so=%0b fd=%0b want pt=7 so=0 fd=0", pt_def, so_def, fd_def);
    end
    drive(1'b0, 1'b1, 16'h0007);
    step();
    checks++;
    if (so_def !== 1'b1 || st_def !== 4'd1 || fd_def !== 1'b1 || pt_def !== 8'd0) begin
      failures++;
      $display("FAIL gmr_refire got so=%0b st=%0d fd=%0b pt=%0d want so=1 st=1 fd=1 pt=0",
               so_def, st_def, fd_def, pt_def);
    end
  endtask

  task automatic test_reset_mid();
    weights = {16{3'd7}};
    drive(1'b1, 1'b1, 16'h0003);
    step();
    drive(1'b0, 1'b1, 16'h0001);
    step();
    drive(1'b0, 1'b1, 16'h0003);
    step();
    // u_def: fired at cycle 1, now refractory; u_sat integrating.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({so_def, st_def, fd_def, pt_def} !== 14'd0 || pt_sat !== 8'd0) begin
      failures++;
      $display("FAIL reset_async got so=%0b st=%0d fd=%0b pt=%0d pt_sat=%0d want all 0",
               so_def, st_def, fd_def, pt_def, pt_sat);
    end
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (so_def !== 1'b0 || pt_def !== 8'd0 || pt_sat !== 8'd0) begin
        failures++;
        $display("FAIL reset_noresume c=%0d got so=%0b pt=%0d pt_sat=%0d want 0", c, so_def, pt_def, pt_sat);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    gamma_start = 1'b0;
    valid_in    = 1'b0;
    spikes_in   = '0;
    weights     = '0;
    test_reset();
    test_no_window();
    test_basic_fire();
    test_refractory();
    test_leak();
    test_gamma_mid_refract();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
